// File: rtl/nco_pkg.sv
// Shared definitions for the NCO and its sweep controller: state encoding and
// default widths, so the phase accumulator and the controller stay consistent.
package nco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NCO_INC_W   = 2;
  localparam int NCO_DWELL_W = 8;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control/config bundle between the configuration logic (master) and the
// sweep controller (slave), plus the NCO drive outputs and FSM debug state.
interface nco_sweep_ctrl_if #(
  parameter int INC_W   = nco_pkg::NCO_INC_W,
  parameter int DWELL_W = nco_pkg::NCO_DWELL_W
);
  import nco_pkg::*;

  // start is a request taken only while the controller is IDLE; busy high
  // means a start will be ignored. abort is honoured in every state.
  logic               start;
  logic               abort;
  logic [INC_W-1:0]   cfg_inc_start;
  logic [INC_W-1:0]   cfg_inc_stop;
  logic [INC_W-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_loop;
  logic [INC_W-1:0]   nco_inc;
  logic               nco_en;
  logic               busy;
  logic               done;
  state_t             state_dbg;

  modport master (
    output start, abort, cfg_inc_start, cfg_inc_stop, cfg_step, cfg_dwell, cfg_loop,
    input  nco_inc, nco_en, busy, done, state_dbg
  );

  modport slave (
    input  start, abort, cfg_inc_start, cfg_inc_stop, cfg_step, cfg_dwell, cfg_loop,
    output nco_inc, nco_en, busy, done, state_dbg
  );

endinterface

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// Loadable down-counter with a zero flag; times how long each increment is held.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Steps the NCO phase increment from a start to a stop value with a per-value
// dwell, optional looping, and a one-cycle done pulse on completion.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int INC_W   = NCO_INC_W,
  parameter int DWELL_W = NCO_DWELL_W
) (
  input logic             clk,
  input logic             rst,
  nco_sweep_ctrl_if.slave sif
);

  localparam logic [INC_W-1:0] STEP_ONE = INC_W'(1);

  state_t             state_q, state_d;
  logic [INC_W-1:0]   inc_q, inc_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [INC_W-1:0]   start_q, stop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q, up_q;
  logic               latch_cfg;

  logic               tmr_clr, tmr_load, tmr_dec, tmr_zero;
  logic [DWELL_W-1:0] tmr_load_val;

  logic [INC_W:0]     sum_ext, dif_ext;
  logic [INC_W-1:0]   step_val;

  dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Extra carry/borrow bit detects wrap of the INC_W range; both wrap and
  // overshoot clamp to the stop value.
  assign sum_ext = {1'b0, inc_q} + {1'b0, step_q};
  assign dif_ext = {1'b0, inc_q} - {1'b0, step_q};

  always_comb begin
    step_val = stop_q;
    if (up_q) begin
      if (!sum_ext[INC_W] && (sum_ext[INC_W-1:0] <= stop_q)) step_val = sum_ext[INC_W-1:0];
    end else begin
      if (!dif_ext[INC_W] && (dif_ext[INC_W-1:0] >= stop_q)) step_val = dif_ext[INC_W-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    inc_d        = inc_q;
    en_d         = en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    latch_cfg    = 1'b0;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = dwell_q;
    case (state_q)
      ST_IDLE: begin
        inc_d  = '0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (sif.start && !sif.abort) begin
          latch_cfg    = 1'b1;
          state_d      = ST_RUN;
          inc_d        = sif.cfg_inc_start;
          en_d         = 1'b1;
          busy_d       = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = sif.cfg_dwell;
        end
      end
      ST_RUN: begin
        if (sif.abort) begin
          state_d = ST_IDLE;
          inc_d   = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          tmr_clr = 1'b1;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (inc_q != stop_q) begin
          inc_d    = step_val;
          tmr_load = 1'b1;
        end else if (loop_q) begin
          inc_d    = start_q;
          tmr_load = 1'b1;
        end else begin
          state_d = ST_DONE;
          inc_d   = '0;
          en_d    = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        inc_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      inc_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= STEP_ONE;
      dwell_q <= '0;
      loop_q  <= 1'b0;
      up_q    <= 1'b1;
    end else if (latch_cfg) begin
      start_q <= sif.cfg_inc_start;
      stop_q  <= sif.cfg_inc_stop;
      step_q  <= (sif.cfg_step == '0) ? STEP_ONE : sif.cfg_step;
      dwell_q <= sif.cfg_dwell;
      loop_q  <= sif.cfg_loop;
      up_q    <= (sif.cfg_inc_stop >= sif.cfg_inc_start);
    end
  end

  assign sif.nco_inc   = inc_q;
  assign sif.nco_en    = en_q;
  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.state_dbg = state_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: per-cycle expected output words are
// queued from a reference sweep model and compared on the falling edge.
module tb_nco_sweep_ctrl;
  import nco_pkg::*;

  localparam int INC_W   = 2;
  localparam int DWELL_W = 8;
  localparam int W       = INC_W + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nco_sweep_ctrl_if #(.INC_W(INC_W), .DWELL_W(DWELL_W)) sif ();

  nco_sweep_ctrl #(.INC_W(INC_W), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  // Word layout: {nco_en, nco_inc, busy, done}
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [W-1:0] pack(input logic en, input logic [INC_W-1:0] inc,
                                        input logic b, input logic d);
    return {en, inc, b, d};
  endfunction

  function automatic logic [W-1:0] observed();
    return {sif.nco_en, sif.nco_inc, sif.busy, sif.done};
  endfunction

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(pack(1'b0, '0, 1'b0, 1'b0));
  endtask

  // Reference model of a non-looping sweep, followed by DONE and one IDLE cycle.
  task automatic push_sweep(input int s0, input int s1, input int st, input int dw);
    int v, n, s;
    bit up;
    s  = (st == 0) ? 1 : st;
    up = (s1 >= s0);
    v  = s0;
    forever begin
      for (int k = 0; k <= dw; k++) exp_q.push_back(pack(1'b1, INC_W'(v), 1'b1, 1'b0));
      if (v == s1) break;
      n = up ? v + s : v - s;
      if (up && n > s1) n = s1;
      if (!up && n < s1) n = s1;
      v = n;
    end
    exp_q.push_back(pack(1'b0, '0, 1'b1, 1'b1));
    push_idle(1);
  endtask

  task automatic start_sweep(input int s0, input int s1, input int st, input int dw, input bit lp);
    @(negedge clk);
    sif.cfg_inc_start = INC_W'(s0);
    sif.cfg_inc_stop  = INC_W'(s1);
    sif.cfg_step      = INC_W'(st);
    sif.cfg_dwell     = DWELL_W'(dw);
    sif.cfg_loop      = lp;
    sif.start         = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
  endtask

  // Drains the queue one word per cycle; optionally pulses start with fresh
  // random config at index poke_at to show mid-sweep starts are ignored.
  task automatic check_trace(input string name, input int poke_at);
    logic [W-1:0] e, o;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cyc%0d: en/inc/busy/done got %b required %b", name, i, o, e);
      end
      if (poke_at >= 0 && i == poke_at) begin
        sif.start         = 1'b1;
        sif.cfg_inc_start = INC_W'($urandom_range(0, 3));
        sif.cfg_inc_stop  = INC_W'($urandom_range(0, 1));
        sif.cfg_step      = INC_W'($urandom_range(0, 3));
        sif.cfg_dwell     = DWELL_W'($urandom_range(0, 7));
        sif.cfg_loop      = 1'($urandom_range(0, 1));
      end else if (poke_at >= 0 && i == poke_at + 1) begin
        sif.start = 1'b0;
      end
      i++;
    end
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    sif.start         = 1'b0;
    sif.abort         = 1'b0;
    sif.cfg_inc_start = '0;
    sif.cfg_inc_stop  = '0;
    sif.cfg_step      = '0;
    sif.cfg_dwell     = '0;
    sif.cfg_loop      = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (observed() !== pack(1'b0, '0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", observed(), pack(1'b0, '0, 1'b0, 1'b0));
    end
    checks++;
    if (sif.state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", sif.state_dbg, ST_IDLE);
    end
    rst = 1'b0;
    push_idle(3);
    check_trace("reset_idle", -1);
  endtask

  task automatic test_up_sweep();
    start_sweep(0, 3, 1, 1, 1'b0);
    push_sweep(0, 3, 1, 1);
    check_trace("up_sweep", -1);
  endtask

  task automatic test_down_clamp();
    start_sweep(3, 0, 2, 0, 1'b0);
    push_sweep(3, 0, 2, 0);
    check_trace("down_clamp", -1);
    start_sweep(0, 2, 0, 0, 1'b0);
    push_sweep(0, 2, 0, 0);
    check_trace("step_zero", -1);
    start_sweep(2, 3, 3, 1, 1'b0);
    push_sweep(2, 3, 3, 1);
    check_trace("wrap_clamp", -1);
  endtask

  task automatic test_loop_abort();
    start_sweep(1, 2, 1, 0, 1'b1);
    for (int k = 0; k < 6; k++) exp_q.push_back(pack(1'b1, INC_W'((k % 2) + 1), 1'b1, 1'b0));
    check_trace("loop", -1);
    sif.abort = 1'b1;
    @(posedge clk);
    #1 sif.abort = 1'b0;
    push_idle(3);
    check_trace("abort", -1);
  endtask

  task automatic test_start_while_busy();
    start_sweep(2, 2, 1, 3, 1'b0);
    push_sweep(2, 2, 1, 3);
    push_idle(3);
    check_trace("start_busy", 1);
  endtask

  task automatic test_async_reset();
    start_sweep(0, 3, 1, 2, 1'b0);
    for (int k = 0; k < 4; k++) exp_q.push_back(pack(1'b1, INC_W'(k / 3), 1'b1, 1'b0));
    check_trace("pre_reset", -1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (observed() !== pack(1'b0, '0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL async_reset: got %b required %b", observed(), pack(1'b0, '0, 1'b0, 1'b0));
    end
    #1 rst = 1'b0;
    push_idle(4);
    check_trace("post_reset_idle", -1);
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    sif.cfg_inc_start = 2'd0;
    sif.cfg_inc_stop  = 2'd3;
    sif.start         = 1'b1;
    sif.abort         = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    push_idle(3);
    check_trace("start_abort_idle", -1);
  endtask

  task automatic test_random();
    int s0, s1, st, dw;
    for (int r = 0; r < 6; r++) begin
      s0 = $urandom_range(0, 3);
      s1 = $urandom_range(0, 3);
      st = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      start_sweep(s0, s1, st, dw, 1'b0);
      push_sweep(s0, s1, st, dw);
      check_trace("random", -1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_up_sweep();
    test_down_clamp();
    test_loop_abort();
    test_start_while_busy();
    test_async_reset();
    test_start_abort_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sweep controller for the LUT NCO phase accumulator. It owns the accumulator's `inc` and `EN` inputs and steps the phase increment from a start value to a stop value, up or down. Each increment value is held for a programmable dwell, with optional looping. It sits between the configuration/control logic and the `nco`, so frequency sweeps and chirps run without per-cycle software intervention.

## Interface
Parameters:
- `INC_W`, default 2: increment width. Matches the NCO `inc` width.
- `DWELL_W`, default 8: dwell counter width.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a sweep. Sampled only in IDLE.
- `abort`, in, 1: terminate a sweep. Sampled in every state.
- `cfg_inc_start`, in, INC_W: first increment value.
- `cfg_inc_stop`, in, INC_W: last increment value.
- `cfg_step`, in, INC_W: increment step magnitude. A value of 0 is treated as 1.
- `cfg_dwell`, in, DWELL_W: each increment value is held for `cfg_dwell+1` cycles.
- `cfg_loop`, in, 1: when 1, the sweep restarts at start after reaching stop.
- `nco_inc`, out, INC_W: drives NCO `inc`.
- `nco_en`, out, 1: drives NCO `EN`.
- `busy`, out, 1: high from the cycle after an accepted start through the DONE cycle.
- `done`, out, 1: one-cycle pulse when a non-looping sweep completes.

## Operation
- All outputs are registered. Reset values: `nco_inc`=0, `nco_en`=0, `busy`=0, `done`=0. Reset state is IDLE.
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - Outputs hold their reset values.
  - If `start`=1 and `abort`=0, latch all `cfg_*` inputs and go to RUN.
  - On entry to RUN: `nco_inc`=`cfg_inc_start`, dwell counter=`cfg_dwell`.
  - Direction is latched as up if stop ≥ start, otherwise down.
- **RUN:**
  - Outputs are `nco_en`=1 and `busy`=1.
  - While the dwell counter is nonzero, decrement it.
  - When the dwell counter is 0 and `nco_inc` ≠ stop, step `nco_inc` by step in the latched direction and reload the dwell counter.
  - Clamp: if the step would pass stop, or would wrap the INC_W range, load stop instead.
  - When the dwell counter is 0 and `nco_inc` = stop:
    - if `cfg_loop`=1, reload start and the dwell counter;
    - otherwise go to DONE.
- **DONE:**
  - Outputs are `nco_en`=0, `nco_inc`=0, `busy`=1, `done`=1.
  - Unconditionally go to IDLE on the next cycle.
- **abort:**
  - Valid from RUN or DONE.
  - Next state is IDLE with all outputs at reset values. No `done` pulse.
  - `abort` asserted together with `start` in IDLE: abort wins and the block stays IDLE.
- `start` is ignored while `busy`=1. `cfg_*` changes during a sweep have no effect; the values latched at start are used.
- Edge cases:
  - start = stop: the single value is held `cfg_dwell+1` cycles, then DONE (or repeats if looping).
  - `rst` asserted mid-sweep: outputs go to reset values immediately, asynchronously, with no `done` pulse.

## Timing
- `start` high at edge k: `nco_en`=1 and `nco_inc`=start are visible after edge k.
- Every increment value is presented for exactly `cfg_dwell+1` cycles, including the final value.
- Total `nco_en`-high cycles for a non-looping sweep = N·(`cfg_dwell`+1), where N is the number of distinct values including the clamped stop.
- `done` is high in the cycle immediately after the last `nco_en`-high cycle. The earliest accepted next start is the cycle after DONE.
- Abort latency: 1 edge.

## Structure
- A shared package `nco_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - defaults for INC_W and DWELL_W, so `nco` and this block stay width-consistent.
- The natural sub-module is `dwell_timer`, a loadable down-counter with a zero flag. The FSM and step/clamp arithmetic stay in the top module.

## Test plan
- **Up-sweep:** start=0, stop=3, step=1, dwell=1. Expect `nco_inc` = 0,0,1,1,2,2,3,3 with `nco_en`=1 for 8 cycles, then `done`=1 for 1 cycle, then IDLE.
- **Down-sweep with clamp:** start=3, stop=0, step=2, dwell=0. Expect `nco_inc` = 3,1,0, then `done`. Step 0 with start=0, stop=2 gives 0,1,2.
- **Loop plus abort:** start=1, stop=2, step=1, dwell=0, loop=1. Expect 1,2,1,2,… with no `done`. Assert `abort` → `nco_en`=0, `busy`=0 after one edge, no `done`.
- **Start while busy:** pulse `start` with new cfg mid-sweep. Expect the sweep to continue unchanged. start=stop=2, dwell=3 gives four cycles of 2, then `done`.
- **Async reset mid-RUN:** assert `rst` between clock edges. Expect all outputs 0 before the next edge. After release, the block stays IDLE until `start`.
- **Simultaneous start and abort in IDLE:** expect no sweep, `busy` stays 0.
